// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one request/acknowledge memory port between fetch and load/store.
// Define FETCH_STARVE_GUARD_EN to compile in the fetch starvation guard (strict data priority otherwise).
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic [DW-1:0]   if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_wstrb,
   output logic            d_gnt,
   output logic [DW-1:0]   d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wstrb,
   input  logic            m_ack,
   input  logic [DW-1:0]   m_rdata,
   output logic            owner,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t state, state_nxt;
   logic   pick_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (if_req || d_req) state_nxt = BUSY;
         BUSY:    if (m_ack) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grants come straight from the state so an asynchronous reset removes them at once.
   assign busy   = (state != IDLE);
   assign if_gnt = (state == RESP) && !owner;
   assign d_gnt  = (state == RESP) && owner;

`ifdef FETCH_STARVE_GUARD_EN
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  starve_cnt <= '0;
      else if (!if_req || if_gnt)               starve_cnt <= '0;
      else if (d_gnt && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
   end

   assign pick_data = d_req && !(if_req && (starve_cnt == STARVE_LIM));
`else
   logic unused_starve_max;
   assign unused_starve_max = ^STARVE_MAX;
   assign pick_data         = d_req;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_wstrb  <= '0;
         owner    <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req || d_req) begin
                  m_req <= 1'b1;
                  owner <= pick_data;
                  if (pick_data) begin
                     m_we    <= d_we;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                     m_wstrb <= d_wstrb;
                  end else begin
                     m_we    <= 1'b0;
                     m_addr  <= if_addr;
                     m_wdata <= '0;
                     m_wstrb <= '0;
                  end
               end
            end
            BUSY: begin
               // Stores leave d_rdata untouched; m_we still holds the command type.
               if (m_ack) begin
                  m_req <= 1'b0;
                  if (!owner)     if_rdata <= m_rdata;
                  else if (!m_we) d_rdata  <= m_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int STARVE_MAX = 4;
`ifdef FETCH_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [SW-1:0] d_wstrb = '0;
   logic          d_gnt;
   logic [DW-1:0] d_rdata;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic          m_ack = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic          owner;
   logic          busy;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ack(m_ack), .m_rdata(m_rdata), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one outstanding memory command, then one grant cycle.
   bit            pend = 1'b0;
   bit            grant_now = 1'b0;
   bit            cur_data = 1'b0;
   bit            cur_we = 1'b0;
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_wdata = '0;
   logic [SW-1:0] cur_wstrb = '0;
   logic [DW-1:0] exp_if_rdata = '0;
   logic [DW-1:0] exp_d_rdata = '0;
   int            starve = 0;

   initial begin : compare
      bit s_if_req, s_d_req, s_d_we, s_m_ack, take_data, new_grant;
      logic [AW-1:0] s_if_addr, s_d_addr;
      logic [DW-1:0] s_d_wdata, s_m_rdata;
      logic [SW-1:0] s_d_wstrb;
      int nstarve;
      forever begin
         @(posedge clk);
         s_if_req = if_req;  s_if_addr = if_addr;
         s_d_req = d_req;    s_d_we = d_we;   s_d_addr = d_addr;
         s_d_wdata = d_wdata; s_d_wstrb = d_wstrb;
         s_m_ack = m_ack;    s_m_rdata = m_rdata;
         if (rst) begin
            pend = 0; grant_now = 0; cur_data = 0;
            exp_if_rdata = '0; exp_d_rdata = '0; starve = 0;
         end else begin
            take_data = s_d_req && !(GUARD && s_if_req && starve == STARVE_MAX);
            if (!s_if_req || (grant_now && !cur_data)) nstarve = 0;
            else if (grant_now && cur_data)            nstarve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else                                       nstarve = starve;
            new_grant = 0;
            if (grant_now) begin
               // transaction finished, next arbitration on the following edge
            end else if (pend) begin
               if (s_m_ack) begin
                  pend = 0;
                  new_grant = 1;
                  if (!cur_data)    exp_if_rdata = s_m_rdata;
                  else if (!cur_we) exp_d_rdata  = s_m_rdata;
               end
            end else if (s_if_req || s_d_req) begin
               pend = 1;
               cur_data = take_data;
               if (take_data) begin
                  cur_we = s_d_we; cur_addr = s_d_addr; cur_wdata = s_d_wdata; cur_wstrb = s_d_wstrb;
               end else begin
                  cur_we = 0; cur_addr = s_if_addr; cur_wdata = '0; cur_wstrb = '0;
               end
            end
            grant_now = new_grant;
            starve = nstarve;
         end
         #1;
         chk("m_req", m_req, pend);
         if (pend) begin
            chk("m_we", m_we, cur_we);
            chk("m_addr", m_addr, cur_addr);
            chk("m_wstrb", m_wstrb, cur_wstrb);
            if (cur_data) chk("m_wdata", m_wdata, cur_wdata);
         end
         chk("busy", busy, pend || grant_now);
         if (pend || grant_now) chk("owner", owner, cur_data);
         chk("if_gnt", if_gnt, grant_now && !cur_data);
         chk("d_gnt", d_gnt, grant_now && cur_data);
         chk("gnt_excl", if_gnt && d_gnt, 1'b0);
         chk("if_rdata", if_rdata, exp_if_rdata);
         chk("d_rdata", d_rdata, exp_d_rdata);
      end
   end

   // Stimulus agents: requesters hold until granted; memory answers with random latency.
   bit auto_mem = 0, auto_req = 0, if_hold = 0, d_hold = 0;
   int if_rate = 0, d_rate = 0, lat_max = 0, stray_pct = 0, lat_left = -1;
   int if_gnts = 0, d_gnts = 0;

   task automatic new_data_cmd();
      d_we = 1'($urandom_range(1, 0));
      d_addr = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      d_wstrb = 4'($urandom);
   endtask

   task automatic tick();
      @(negedge clk);
      if (if_gnt) if_gnts++;
      if (d_gnt)  d_gnts++;
      if (auto_mem) begin
         m_ack = 1'b0;
         if (m_req) begin
            if (lat_left < 0) lat_left = $urandom_range(lat_max, 0);
            if (lat_left == 0) begin
               m_ack = 1'b1; m_rdata = $urandom; lat_left = -1;
            end else lat_left--;
         end else begin
            lat_left = -1;
            if ($urandom_range(99, 0) < stray_pct) begin
               m_ack = 1'b1; m_rdata = $urandom;
            end
         end
      end
      if (auto_req) begin
         if (if_gnt) begin
            if (if_hold || $urandom_range(99, 0) < if_rate) if_addr = $urandom & 32'hFFFF_FFFC;
            else if_req = 1'b0;
         end else if (!if_req && (if_hold || $urandom_range(99, 0) < if_rate)) begin
            if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (d_gnt) begin
            if (d_hold || $urandom_range(99, 0) < d_rate) new_data_cmd();
            else d_req = 1'b0;
         end else if (!d_req && (d_hold || $urandom_range(99, 0) < d_rate)) begin
            d_req = 1'b1; new_data_cmd();
         end
      end
   endtask

   initial begin : stim
      int dcnt, g0;
      bit fetched;
      repeat (2) @(negedge clk);
      chk("rst_m_req", m_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_if_rdata", if_rdata, 0);
      rst = 1'b0;

      // single fetch, ack in the first m_req cycle
      tick(); if_req = 1; if_addr = 32'h10;
      tick(); chk("t1_m_req", m_req, 1); chk("t1_m_addr", m_addr, 32'h10); chk("t1_m_we", m_we, 0);
      m_ack = 1; m_rdata = 32'h13;
      tick(); m_ack = 0; chk("t1_if_gnt", if_gnt, 1); chk("t1_if_rdata", if_rdata, 32'h13); if_req = 0;
      tick(); chk("t1_busy", busy, 0);

      // simultaneous requests: load wins, fetch follows
      tick(); if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = 0; d_wstrb = 0;
      tick(); chk("t3_owner_d", owner, 1); chk("t3_m_addr_d", m_addr, 32'h200); m_ack = 1; m_rdata = 32'h203;
      tick(); m_ack = 0; chk("t3_d_gnt", d_gnt, 1); chk("t3_if_gnt_lo", if_gnt, 0); chk("t3_d_rdata", d_rdata, 32'h203); d_req = 0;
      tick(); chk("t3_gap_busy", busy, 0);
      tick(); chk("t3_owner_f", owner, 0); chk("t3_m_addr_f", m_addr, 32'h4); m_ack = 1; m_rdata = 32'h7;
      tick(); m_ack = 0; chk("t3_if_gnt", if_gnt, 1); chk("t3_if_rdata", if_rdata, 32'h7); chk("t3_d_gnt_lo", d_gnt, 0); if_req = 0;
      tick(); chk("t3_busy", busy, 0);

      // stray ack in IDLE
      m_ack = 1; m_rdata = 32'hBAD0_BAD0;
      tick(); m_ack = 0;
      chk("t6_busy", busy, 0); chk("t6_m_req", m_req, 0); chk("t6_if_rdata", if_rdata, 32'h7); chk("t6_d_rdata", d_rdata, 32'h203);

      // store with three wait cycles
      tick(); d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_m_req", m_req, 1); chk("t2_m_addr", m_addr, 32'h100); chk("t2_m_we", m_we, 1);
         chk("t2_m_wdata", m_wdata, 32'hDEADBEEF); chk("t2_m_wstrb", m_wstrb, 4'hF); chk("t2_no_gnt", d_gnt, 0);
         if (i == 3) begin m_ack = 1; m_rdata = 32'h5555_5555; end
      end
      tick(); m_ack = 0; chk("t2_d_gnt", d_gnt, 1); chk("t2_d_rdata", d_rdata, 32'h203); d_req = 0;
      tick(); chk("t2_busy", busy, 0);

      // reset while waiting for m_ack
      tick(); if_req = 1; if_addr = 32'h80;
      tick(); chk("t5_m_req", m_req, 1);
      tick(); chk("t5_busy", busy, 1);
      #2 rst = 1;
      #1 chk("t5_rst_m_req", m_req, 0); chk("t5_rst_busy", busy, 0);
      chk("t5_rst_if_gnt", if_gnt, 0); chk("t5_rst_d_gnt", d_gnt, 0); chk("t5_rst_rdata", if_rdata, 0);
      tick(); rst = 0;
      tick(); chk("t5_m_req2", m_req, 1); chk("t5_m_addr2", m_addr, 32'h80); m_ack = 1; m_rdata = 32'h81;
      tick(); m_ack = 0; chk("t5_if_gnt", if_gnt, 1); chk("t5_if_rdata", if_rdata, 32'h81); if_req = 0;
      tick(); chk("t5_busy2", busy, 0);

      // both requesters held continuously
      auto_mem = 1; lat_max = 2; stray_pct = 0;
      tick(); if_req = 1; if_addr = 32'h40; d_req = 1; new_data_cmd();
      auto_req = 1; if_hold = 1; d_hold = 1;
      if (GUARD) begin
         for (int r = 0; r < 2; r++) begin
            dcnt = 0; fetched = 0;
            for (int c = 0; c < 200 && !fetched; c++) begin
               tick();
               if (d_gnt) dcnt++;
               if (if_gnt) fetched = 1;
            end
            chk("guard_fetch_seen", fetched, 1);
            chk("guard_data_grants", dcnt, STARVE_MAX);
         end
      end else begin
         g0 = if_gnts;
         repeat (60) tick();
         chk("noguard_fetch_waits", if_gnts - g0, 0);
         chk("noguard_data_flow", d_gnts > 8, 1);
         d_hold = 0; d_rate = 0;
         fetched = 0;
         for (int c = 0; c < 60 && !fetched; c++) begin
            tick();
            if (if_gnt) fetched = 1;
         end
         chk("noguard_fetch_after_drop", fetched, 1);
      end
      if_hold = 0; d_hold = 0; if_rate = 0; d_rate = 0;
      for (int c = 0; c < 100 && (if_req || d_req || busy); c++) tick();
      chk("drain_idle", {if_req, d_req, busy}, 3'b000);

      // randomized traffic with stray acks and occasional resets
      if_rate = 30; d_rate = 40; lat_max = 3; stray_pct = 20;
      for (int c = 0; c < 4000; c++) begin
         tick();
         if ($urandom_range(999, 0) < 3) begin
            #2 rst = 1;
            @(negedge clk);
            rst = 0;
         end
      end
      chk("random_grants_seen", (if_gnts > 50) && (d_gnts > 50), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
